// File: rtl/reg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_sched_pkg
// Brief    : Shared constants, FSM state type and helpers for reg_write_sched.
// Revision : 1.0
// ============================================================================
package reg_sched_pkg;

    localparam int NREGS  = 8;
    localparam int REG_AW = 3;
    localparam int REG_DW = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        return NREGS'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; grants the first request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   ptr
);

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_cand;
    logic            w_found;

    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                w_gnt[w_cand]  = 1'b1;
                w_idx          = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign gnt = w_gnt;
    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sched
// Brief    : Write-port scheduler for the 8x8 register bank with busy
//            scoreboard and flush/drain. Option: REG_WRITE_SCHED_ZERO_LOCK_EN
//            makes register 0 read-only zero.
// Revision : 1.0
// ============================================================================
module reg_write_sched
    import reg_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = REG_DW,
    parameter int AW   = REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    output logic               rsv_ok,
    output logic [NREGS-1:0]   busy,
    input  logic               flush,
    output logic               flush_done,
    output logic               err_unrsv,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REG_WRITE_SCHED_ZERO_LOCK_EN
    localparam bit ZERO_LOCK = 1'b1;
`else
    localparam bit ZERO_LOCK = 1'b0;
`endif

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [NREGS-1:0] r_busy;
    logic             r_err;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [DW-1:0]    r_wr_data;

    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_unused_ptr;
    logic             w_gnt_any;
    logic [AW-1:0]    w_gnt_addr;
    logic [DW-1:0]    w_gnt_data;
    logic             w_lock_gnt;
    logic             w_lock_rsv;
    logic             w_write;
    logic             w_rsv_ok;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_next;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_gnt_any),
        .gnt     (w_gnt),
        .ptr     (w_unused_ptr)
    );

    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_addr = req_addr[i*AW +: AW];
                w_gnt_data = req_data[i*DW +: DW];
            end
        end
    end

    // Locked register 0 completes the handshake but never reaches the bank.
    assign w_lock_gnt = ZERO_LOCK && (w_gnt_addr == '0);
    assign w_lock_rsv = ZERO_LOCK && (rsv_addr == '0);
    assign w_write    = w_gnt_any && !w_lock_gnt;

    always_comb begin
        w_rsv_ok = 1'b0;
        if (rsv_valid && (r_state == RUN)) begin
            w_rsv_ok = w_lock_rsv || !r_busy[rsv_addr] ||
                       (w_gnt_any && (w_gnt_addr == rsv_addr));
        end
    end

    // Set is applied after clear so a same-cycle re-reservation keeps busy high.
    assign w_clr       = w_gnt_any ? reg_onehot(w_gnt_addr) : '0;
    assign w_set       = (w_rsv_ok && !w_lock_rsv) ? reg_onehot(rsv_addr) : '0;
    assign w_busy_next = (r_busy & ~w_clr) | w_set;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (flush) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((w_busy_next == '0) && !(|req_valid)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_busy    <= '0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
                if (!r_busy[w_gnt_addr]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign req_ready  = w_gnt;
    assign rsv_ok     = w_rsv_ok;
    assign busy       = r_busy;
    assign flush_done = (r_state == DONE);
    assign err_unrsv  = r_err;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_sched
// Brief    : Directed scoreboard bench for reg_write_sched (NREQ=2).
// Revision : 1.0
// ============================================================================
module tb_reg_write_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [5:0]  req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        rsv_valid;
    logic [2:0]  rsv_addr;
    logic        rsv_ok;
    logic [7:0]  busy;
    logic        flush;
    logic        flush_done;
    logic        err_unrsv;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    int          n_chk;
    int          n_pass;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;

    reg_write_sched #(
        .NREQ (2),
        .DW   (8),
        .AW   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ok     (rsv_ok),
        .busy       (busy),
        .flush      (flush),
        .flush_done (flush_done),
        .err_unrsv  (err_unrsv),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit reaches_bank(input logic [2:0] a);
`ifdef REG_WRITE_SCHED_ZERO_LOCK_EN
        return a != 3'd0;
`else
        return 1'b1;
`endif
    endfunction

    // One cycle of stimulus: drive, check combinational outputs mid-cycle,
    // queue the writes expected from the predicted grants, then step.
    task automatic cyc(input string nm, input logic [1:0] v,
                       input logic [2:0] a0, input logic [7:0] d0,
                       input logic [2:0] a1, input logic [7:0] d1,
                       input logic rv, input logic [2:0] ra, input logic fl,
                       input logic [1:0] e_rdy, input logic e_ok);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        rsv_valid = rv;
        rsv_addr  = ra;
        flush     = fl;
        @(negedge clk);
        chk({nm, " ready"}, 32'(req_ready), 32'(e_rdy));
        chk({nm, " rsv_ok"}, 32'(rsv_ok), 32'(e_ok));
        if (e_rdy[0] && reaches_bank(a0)) exp_q.push_back({a0, d0});
        if (e_rdy[1] && reaches_bank(a1)) exp_q.push_back({a1, d1});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsv_valid = 1'b0;
    endtask

    task automatic rsv(input string nm, input logic [2:0] ra, input logic fl, input logic e_ok);
        cyc(nm, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, ra, fl, 2'b00, e_ok);
    endtask

    task automatic idle(input string nm, input logic fl);
        cyc(nm, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 3'd0, fl, 2'b00, 1'b0);
    endtask

    // Write monitor: every bank write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL wb unexpected: got addr %0d data %0h, required no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb addr", 32'(wr_addr), 32'(mon_e[10:8]));
                chk("wb data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wr_en", 32'(wr_en), 32'h0);
        chk("rst wr_addr", 32'(wr_addr), 32'h0);
        chk("rst wr_data", 32'(wr_data), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst err", 32'(err_unrsv), 32'h0);
        chk("rst flush_done", 32'(flush_done), 32'h0);
        rst = 1'b0;

        // Contention: ptr starts at 0, grants alternate 0,1,0,1.
        rsv("rsv r1", 3'd1, 1'b0, 1'b1);
        rsv("rsv r2", 3'd2, 1'b0, 1'b1);
        rsv("rsv r3", 3'd3, 1'b0, 1'b1);
        rsv("rsv r4", 3'd4, 1'b0, 1'b1);
        chk("busy r1-r4", 32'(busy), 32'h1E);
        cyc("cont0", 2'b11, 3'd1, 8'h11, 3'd2, 8'h22, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("cont0 wr_en", 32'(wr_en), 32'h1);
        cyc("cont1", 2'b11, 3'd3, 8'h33, 3'd2, 8'h22, 1'b0, 3'd0, 1'b0, 2'b10, 1'b0);
        chk("cont1 wr_en", 32'(wr_en), 32'h1);
        cyc("cont2", 2'b11, 3'd3, 8'h33, 3'd4, 8'h44, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("cont2 wr_en", 32'(wr_en), 32'h1);
        cyc("cont3", 2'b11, 3'd3, 8'h33, 3'd4, 8'h44, 1'b0, 3'd0, 1'b0, 2'b10, 1'b0);
        chk("cont3 wr_en", 32'(wr_en), 32'h1);
        idle("cont idle", 1'b0);
        chk("cont idle wr_en", 32'(wr_en), 32'h0);
        chk("cont busy", 32'(busy), 32'h0);
        chk("cont err", 32'(err_unrsv), 32'h0);

        // Single write to R3 (ptr=0).
        rsv("rsv r3b", 3'd3, 1'b0, 1'b1);
        chk("busy r3", 32'(busy), 32'h08);
        cyc("wr r3", 2'b01, 3'd3, 8'h5A, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("wr r3 busy", 32'(busy), 32'h00);
        chk("wr r3 wr_en", 32'(wr_en), 32'h1);
        chk("wr r3 err", 32'(err_unrsv), 32'h0);

        // Same-cycle clear and reserve of R5 (ptr=1).
        rsv("rsv r5", 3'd5, 1'b0, 1'b1);
        chk("busy r5", 32'(busy), 32'h20);
        cyc("clr+rsv r5", 2'b10, 3'd0, 8'h00, 3'd5, 8'h77, 1'b1, 3'd5, 1'b0, 2'b10, 1'b1);
        chk("clr+rsv busy", 32'(busy), 32'h20);
        chk("clr+rsv err", 32'(err_unrsv), 32'h0);
        cyc("wr r5", 2'b01, 3'd5, 8'h78, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("wr r5 busy", 32'(busy), 32'h00);

        // Drain with R2 and R6 outstanding (ptr=1).
        rsv("rsv r2b", 3'd2, 1'b0, 1'b1);
        rsv("rsv r6", 3'd6, 1'b0, 1'b1);
        chk("busy r2 r6", 32'(busy), 32'h44);
        idle("flush", 1'b1);
        rsv("drain rsv r1", 3'd1, 1'b1, 1'b0);
        chk("drain busy", 32'(busy), 32'h44);
        chk("drain flush_done", 32'(flush_done), 32'h0);
        cyc("drain wr r2", 2'b10, 3'd0, 8'h00, 3'd2, 8'hA2, 1'b0, 3'd0, 1'b1, 2'b10, 1'b0);
        cyc("drain wr r6", 2'b01, 3'd6, 8'hA6, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 2'b01, 1'b0);
        chk("drain busy clr", 32'(busy), 32'h00);
        chk("drain pending done", 32'(flush_done), 32'h0);
        idle("drain idle", 1'b1);
        chk("flush_done pulse", 32'(flush_done), 32'h1);
        idle("done", 1'b0);
        chk("flush_done drop", 32'(flush_done), 32'h0);
        rsv("run rsv r1", 3'd1, 1'b0, 1'b1);
        chk("run busy r1", 32'(busy), 32'h02);
        cyc("wr r1", 2'b10, 3'd0, 8'h00, 3'd1, 8'h11, 1'b0, 3'd0, 1'b0, 2'b10, 1'b0);
        chk("wr r1 busy", 32'(busy), 32'h00);
        chk("wr r1 err", 32'(err_unrsv), 32'h0);

        // Unreserved write to R4 (ptr=0).
        cyc("unrsv r4", 2'b01, 3'd4, 8'hC4, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("unrsv err", 32'(err_unrsv), 32'h1);
        chk("unrsv wr_en", 32'(wr_en), 32'h1);

        // Reset during a grant (ptr=1): write discarded, state cleared.
        rsv("rsv r7", 3'd7, 1'b0, 1'b1);
        chk("busy r7", 32'(busy), 32'h80);
        req_valid = 2'b10;
        req_addr  = {3'd7, 3'd0};
        req_data  = {8'hE7, 8'h00};
        rst = 1'b1;
        @(negedge clk);
        chk("rst grant ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        chk("rst mid wr_en", 32'(wr_en), 32'h0);
        chk("rst mid busy", 32'(busy), 32'h0);
        chk("rst mid err", 32'(err_unrsv), 32'h0);
        cyc("ptr after rst", 2'b11, 3'd3, 8'h31, 3'd2, 8'h32, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        idle("post ptr idle", 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Register 0 handling (ptr=0).
`ifdef REG_WRITE_SCHED_ZERO_LOCK_EN
        rsv("zl rsv r0", 3'd0, 1'b0, 1'b1);
        chk("zl busy", 32'(busy), 32'h00);
        cyc("zl wr r0", 2'b01, 3'd0, 8'hFF, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("zl wr_en", 32'(wr_en), 32'h0);
        chk("zl busy after", 32'(busy), 32'h00);
        chk("zl err", 32'(err_unrsv), 32'h0);
`else
        rsv("r0 rsv", 3'd0, 1'b0, 1'b1);
        chk("r0 busy", 32'(busy), 32'h01);
        cyc("r0 wr", 2'b01, 3'd0, 8'hFF, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0);
        chk("r0 wr_en", 32'(wr_en), 32'h1);
        chk("r0 busy after", 32'(busy), 32'h00);
        chk("r0 err", 32'(err_unrsv), 32'h0);
`endif
        idle("tail0", 1'b0);
        idle("tail1", 1'b0);
        chk("queue drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_sched.md
# reg_write_sched

Write-port scheduler for the 8 x 8-bit register bank. Shares the bank's single write port between NREQ writeback requesters with round-robin arbitration. Tracks pending destination registers in a busy scoreboard for issue-side hazard checks. Supports a flush/drain sequence. Sits between the execution units and the bank's `write`/`addrw`/`din` inputs.

## Interface
Parameters:
- `NREQ`, 2: number of writeback requesters (2..4).
- `DW`, 8: data width.
- `AW`, 3: register address width (8 registers).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: requester i has a write pending.
- `req_addr` in NREQ*AW: destination of requester i, in slice [i*AW +: AW].
- `req_data` in NREQ*DW: write data of requester i, in slice [i*DW +: DW].
- `req_ready` out NREQ: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsv_valid` in 1: issue stage requests reservation of `rsv_addr`.
- `rsv_addr` in AW: register to reserve.
- `rsv_ok` out 1: combinational; the reservation is accepted this cycle.
- `busy` out 8: scoreboard, one bit per register.
- `flush` in 1: level; request drain.
- `flush_done` out 1: one-cycle pulse when the drain completes.
- `err_unrsv` out 1: sticky; a write was granted to a non-busy register.
- `wr_en` out 1: drives the bank's `write`.
- `wr_addr` out AW: drives the bank's `addrw`.
- `wr_data` out DW: drives the bank's `din`.

## Operation
- Arbitration:
  - Round-robin pointer `ptr` (0..NREQ-1).
  - Grant goes to the first valid requester at or after `ptr`, modulo NREQ.
  - `req_ready` is combinational and has at most one bit set.
  - At most one grant per cycle.
  - After a grant to i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- Writeback register:
  - On a grant, the next edge loads `wr_en`=1, `wr_addr`, and `wr_data` from the granted slice.
  - With no grant, `wr_en`=0 and `wr_addr`/`wr_data` hold their values.
- Scoreboard:
  - A grant to address a clears `busy[a]` at the same edge that `wr_en` rises.
  - An accepted reservation sets `busy[rsv_addr]`.
  - `rsv_ok` = `rsv_valid` & state==RUN & (~`busy[rsv_addr]` | a grant to `rsv_addr` this cycle).
  - When a clear and a set hit the same address in one cycle, the set wins and `busy` stays 1.
  - A granted write to a register with `busy`=0 sets `err_unrsv`. The write still proceeds.
- FSM states RUN, DRAIN, DONE:
  - RUN -> DRAIN when `flush`=1.
  - DRAIN: reservations are refused (`rsv_ok`=0); arbitration continues.
  - DRAIN -> DONE when `busy`==0 after that cycle's clears and no requester is valid.
  - DONE: `flush_done`=1 for exactly this cycle, then -> RUN. If `flush` is still high, the FSM re-enters DRAIN on the next cycle.
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `ptr`=0, `err_unrsv`=0.
  - `flush_done`=0, state=RUN.
- Reset mid-operation:
  - Pending grants are discarded and no write is issued.
  - The scoreboard clears and `ptr` returns to 0.

## Timing
- Request to bank write: a grant in cycle N gives `wr_en`=1 in cycle N+1. The bank captures the data at the end of cycle N+1.
- Back-to-back grants are allowed, one per cycle. Sustained throughput is 1 write/cycle.
- `rsv_ok` and `req_ready` have zero latency: combinational from the current inputs and state.
- `busy` is registered; a reservation becomes visible the cycle after acceptance.
- Minimum `flush` to `flush_done` is 2 cycles (RUN->DRAIN, DRAIN->DONE) when nothing is pending.
- `rst` takes priority over every other input in the same cycle.

## Configuration
- `REG_WRITE_SCHED_ZERO_LOCK_EN` defined: register 0 is read-only zero.
  - Grants to address 0 are still given (`req_ready` handshakes complete), but `wr_en` stays 0 for them.
  - `busy[0]` is never set, and reservations of address 0 always get `rsv_ok`=1 in RUN.
  - `err_unrsv` is never set by address 0.
- Macro undefined: register 0 is handled exactly like registers 1..7.

## Structure
- Package `reg_sched_pkg` holds:
  - constants `NREGS`=8, `REG_AW`=3, `REG_DW`=8;
  - the FSM state typedef (RUN, DRAIN, DONE).
- Sub-module `rr_arbiter`: parameter NREQ; inputs `clk`, `rst`, `req`, `advance`; outputs a one-hot `gnt` and the pointer. Instantiated once.
- Scoreboard, writeback register and FSM live in the top module.

## Test plan
- Single write: reserve R3 (`rsv_ok`=1). Next cycle req0 writes 8'h5A to R3. Expect `wr_en`=1, `wr_addr`=3, `wr_data`=8'h5A one cycle after the grant; `busy[3]` 1->0; `err_unrsv`=0.
- Contention: req0 and req1 both valid every cycle with `ptr`=0. Expect grants 0,1,0,1, and `wr_en` asserted 4 consecutive cycles.
- Same-cycle clear and reserve: R5 busy, req1 granted to R5, and `rsv_addr`=5 in the same cycle. Expect `rsv_ok`=1 and `busy[5]` remains 1 afterwards.
- Drain: R2 and R6 busy, `flush`=1. Expect `rsv_ok`=0 for a reserve of R1. After both writebacks, `flush_done` pulses once and the FSM returns to RUN.
- Unreserved write and reset: write R4 with `busy[4]`=0. Expect `err_unrsv`=1 and the write issued. Assert `rst` during a grant: next cycle `wr_en`=0, `busy`=0, `err_unrsv`=0.
- Zero lock (macro defined): req0 writes 8'hFF to R0. Expect `req_ready[0]`=1, `wr_en` stays 0, `busy[0]`=0.
